// File: rtl/pc_stall_ctrl_pkg.sv
// Shared definitions for the PC / pipeline stall controller.
// State encoding, memory-port owner codes and counter width.
package pc_stall_ctrl_pkg;

    localparam int STALL_CNT_W = 16;

    localparam logic MEM_SEL_I = 1'b0;
    localparam logic MEM_SEL_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DFILL = 3'd2,
        ST_IFILL = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    function automatic logic is_fill(input state_t s);
        return (s == ST_DFILL) || (s == ST_IFILL);
    endfunction

endpackage

// File: rtl/pc_stall_ctrl_cnt.sv
// Saturating up-counter with increment enable.
// Holds at all-ones; cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_stall_ctrl.sv
// PC enable / pipeline stall controller arbitrating cache fills
// over a shared memory port and deferring flushes across stalls.
module pc_stall_ctrl
    import pc_stall_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   hd_i,
    input  logic                   branch_i,
    input  logic                   imiss_i,
    input  logic                   dmiss_i,
    input  logic                   mem_ack_i,
    output logic                   mem_req_o,
    output logic                   mem_sel_o,
    output logic                   ifill_done_o,
    output logic                   dfill_done_o,
    output logic                   pc_enable_o,
    output logic                   stall_o,
    output logic                   flush_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_flush_pend;
    logic   w_flush_pend_nxt;
    logic   w_pc_en;
    logic   w_cnt_inc;
    logic   w_miss;

    assign w_miss = imiss_i | dmiss_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;
        w_pc_en          = 1'b0;
        w_cnt_inc        = 1'b0;
        mem_req_o        = 1'b0;
        mem_sel_o        = MEM_SEL_I;
        ifill_done_o     = 1'b0;
        dfill_done_o     = 1'b0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_flush_pend_nxt = 1'b0;
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                w_pc_en   = ~(hd_i | w_miss);
                stall_o   = w_miss;
                flush_o   = w_pc_en & (branch_i | r_flush_pend);
                w_cnt_inc = ~w_pc_en;
                if (!start_i) begin
                    w_state_nxt      = ST_IDLE;
                    w_flush_pend_nxt = 1'b0;
                end else begin
                    // A live flush consumes the pending flag the same cycle.
                    if (w_pc_en) begin
                        w_flush_pend_nxt = 1'b0;
                    end else begin
                        w_flush_pend_nxt = r_flush_pend | branch_i;
                    end
                    // D-side first: it belongs to the older instruction.
                    if (dmiss_i) begin
                        w_state_nxt = ST_DFILL;
                    end else if (imiss_i) begin
                        w_state_nxt = ST_IFILL;
                    end
                end
            end

            ST_DFILL: begin
                mem_req_o        = 1'b1;
                mem_sel_o        = MEM_SEL_D;
                stall_o          = 1'b1;
                w_cnt_inc        = 1'b1;
                w_flush_pend_nxt = r_flush_pend | branch_i;
                if (mem_ack_i) begin
                    dfill_done_o = 1'b1;
                    if (!start_i) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (imiss_i) begin
                        w_state_nxt = ST_IFILL;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_IFILL: begin
                mem_req_o        = 1'b1;
                mem_sel_o        = MEM_SEL_I;
                stall_o          = 1'b1;
                w_cnt_inc        = 1'b1;
                w_flush_pend_nxt = r_flush_pend | branch_i;
                if (mem_ack_i) begin
                    ifill_done_o = 1'b1;
                    if (!start_i) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (dmiss_i) begin
                        w_state_nxt = ST_DFILL;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                w_state_nxt      = ST_IDLE;
                w_flush_pend_nxt = 1'b0;
            end

            default: begin
                w_state_nxt      = ST_IDLE;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    assign pc_enable_o = w_pc_en;

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_inc (w_cnt_inc),
        .o_cnt (stall_cnt_o)
    );

endmodule
